// File: rtl/multicycle_seq_if.sv
// Handshake/control bundle between the multicycle sequencer and its core.
// The slave side is the sequencer; the master side drives decode and memory status.
interface multicycle_seq_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       Zero;
   logic       mem_ready;
   logic       IRWr;
   logic       PCWr;
   logic [1:0] pc_src;
   logic       RegWr;
   logic       MemRd;
   logic       MemWr;
   logic [2:0] state;
   logic       instr_done;
   logic       illegal;
   logic       bus_err;

   modport master (
      output opcode, funct, Zero, mem_ready,
      input  IRWr, PCWr, pc_src, RegWr, MemRd, MemWr,
      input  state, instr_done, illegal, bus_err
   );

   modport slave (
      input  opcode, funct, Zero, mem_ready,
      output IRWr, PCWr, pc_src, RegWr, MemRd, MemWr,
      output state, instr_done, illegal, bus_err
   );
endinterface

// File: rtl/multicycle_seq.sv
// IF/ID/EX/MEM/WB sequencer for the multicycle MIPS core.
// Decides when IR/PC/regfile/memory enables fire and bounds MEM waits.
module multicycle_seq #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic            Clk,
   input  logic            Reset,
   multicycle_seq_if.slave bus
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] L_LAST = CNT_W'(TIMEOUT - 1);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   logic w_rtype, w_jr, w_itype, w_lw, w_sw;
   logic w_beq, w_j, w_jal, w_legal;

   logic       w_irwr, w_pcwr, w_regwr;
   logic       w_memrd, w_memwr, w_ill, w_berr;
   logic [1:0] w_src;

   assign w_rtype = (bus.opcode == 6'b000000) &&
                    (bus.funct != 6'b001000);
   assign w_jr    = (bus.opcode == 6'b000000) &&
                    (bus.funct == 6'b001000);
   assign w_itype = (bus.opcode[5:3] == 3'b001);
   assign w_lw    = (bus.opcode == 6'b100011);
   assign w_sw    = (bus.opcode == 6'b101011);
   assign w_beq   = (bus.opcode == 6'b000100);
   assign w_j     = (bus.opcode == 6'b000010);
   assign w_jal   = (bus.opcode == 6'b000011);
   assign w_legal = w_rtype | w_jr | w_itype | w_lw |
                    w_sw | w_beq | w_j | w_jal;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IF;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_next    = S_IF;
      w_cnt_nxt = r_cnt;
      w_irwr    = 1'b0;
      w_pcwr    = 1'b0;
      w_regwr   = 1'b0;
      w_memrd   = 1'b0;
      w_memwr   = 1'b0;
      w_ill     = 1'b0;
      w_berr    = 1'b0;
      w_src     = 2'b00;
      unique case (r_state)
         S_IF: begin
            w_irwr = 1'b1;
            w_next = S_ID;
         end
         S_ID: begin
            if (w_j || w_jal) begin
               w_pcwr  = 1'b1;
               w_src   = 2'b10;
               w_regwr = w_jal;
            end else if (!w_legal) begin
               w_ill  = 1'b1;
               w_pcwr = 1'b1;
            end else begin
               w_next = S_EX;
            end
         end
         S_EX: begin
            if (w_rtype || w_itype) begin
               w_next = S_WB;
            end else if (w_lw || w_sw) begin
               w_cnt_nxt = '0;
               w_next    = S_MEM;
            end else if (w_beq) begin
               w_pcwr = 1'b1;
               w_src  = bus.Zero ? 2'b01 : 2'b00;
            end else begin
               w_pcwr = 1'b1;
               w_src  = w_jr ? 2'b11 : 2'b00;
            end
         end
         S_MEM: begin
            w_memrd = w_lw;
            w_memwr = w_sw;
            // completion beats timeout when both land together
            if (bus.mem_ready) begin
               if (w_lw) w_next = S_WB;
               else      w_pcwr = 1'b1;
            end else if (r_cnt == L_LAST) begin
               w_berr = 1'b1;
               w_pcwr = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
               w_next    = S_MEM;
            end
         end
         S_WB: begin
            w_regwr = 1'b1;
            w_pcwr  = 1'b1;
         end
         default: w_next = S_IF;
      endcase
      if (Reset) begin
         w_irwr  = 1'b0;
         w_pcwr  = 1'b0;
         w_regwr = 1'b0;
         w_memrd = 1'b0;
         w_memwr = 1'b0;
         w_ill   = 1'b0;
         w_berr  = 1'b0;
         w_src   = 2'b00;
      end
   end

   assign bus.IRWr       = w_irwr;
   assign bus.PCWr       = w_pcwr;
   assign bus.pc_src     = w_src;
   assign bus.RegWr      = w_regwr;
   assign bus.MemRd      = w_memrd;
   assign bus.MemWr      = w_memwr;
   assign bus.state      = Reset ? 3'd0 : r_state;
   assign bus.instr_done = w_pcwr;
   assign bus.illegal    = w_ill;
   assign bus.bus_err    = w_berr;

endmodule

// File: tb/tb_multicycle_seq.sv
// Scoreboard bench for multicycle_seq: stimulus queues per-instruction
// expectations, a monitor checks them at each retirement (PCWr).
module tb_multicycle_seq;

   logic Clk = 1'b0;
   logic Reset;

   multicycle_seq_if bus();

   multicycle_seq #(
      .TIMEOUT(16),
      .CNT_W  (5)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int cyc;
      int src;
      int irwr;
      int regwr;
      int memrd;
      int memwr;
      int ill;
      int berr;
      int end_st;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   mem_wait = 0;
   bit   idle_ready = 1'b0;
   int   n_done = 0;
   int   st_tr[4] = '{0, 1, 2, 4};

   int a_cyc, a_irwr, a_regwr, a_memrd, a_memwr, a_ill, a_berr;

   task automatic chk(input string nm, input int act, input int want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, want);
      end
   endtask

   function automatic exp_t mk(input int cyc, src, irwr, regwr,
                               memrd, memwr, ill, berr, end_st);
      exp_t e;
      e.cyc = cyc;     e.src = src;     e.irwr = irwr;
      e.regwr = regwr; e.memrd = memrd; e.memwr = memwr;
      e.ill = ill;     e.berr = berr;   e.end_st = end_st;
      return e;
   endfunction

   function automatic int outs();
      return int'({bus.IRWr, bus.PCWr, bus.pc_src, bus.RegWr,
                   bus.MemRd, bus.MemWr, bus.state,
                   bus.instr_done, bus.illegal, bus.bus_err});
   endfunction

   task automatic clr_acc();
      a_cyc = 0; a_irwr = 0; a_regwr = 0; a_memrd = 0;
      a_memwr = 0; a_ill = 0; a_berr = 0;
   endtask

   // data memory model: ready after mem_wait low cycles in MEM
   initial begin : memdrv
      int mcnt;
      mcnt = 0;
      bus.mem_ready = 1'b0;
      forever begin
         @(posedge Clk);
         #1;
         if (bus.state == 3'd3) begin
            bus.mem_ready = (mcnt >= mem_wait);
            mcnt++;
         end else begin
            mcnt = 0;
            bus.mem_ready = idle_ready;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      clr_acc();
      forever begin
         @(negedge Clk);
         if (Reset) begin
            clr_acc();
         end else begin
            a_cyc++;
            a_irwr  += int'(bus.IRWr);
            a_regwr += int'(bus.RegWr);
            a_memrd += int'(bus.MemRd);
            a_memwr += int'(bus.MemWr);
            a_ill   += int'(bus.illegal);
            a_berr  += int'(bus.bus_err);
            if (bus.PCWr) begin
               n_done++;
               chk("instr_done", int'(bus.instr_done), 1);
               if (q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL retire: got unexpected PCWr expected none");
               end else begin
                  e = q.pop_front();
                  chk("cycles", a_cyc, e.cyc);
                  chk("pc_src", int'(bus.pc_src), e.src);
                  chk("irwr_cnt", a_irwr, e.irwr);
                  chk("regwr_cnt", a_regwr, e.regwr);
                  chk("memrd_cnt", a_memrd, e.memrd);
                  chk("memwr_cnt", a_memwr, e.memwr);
                  chk("illegal_cnt", a_ill, e.ill);
                  chk("bus_err_cnt", a_berr, e.berr);
                  chk("end_state", int'(bus.state), e.end_st);
               end
               clr_acc();
            end
         end
      end
   end

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (!bus.PCWr && n < 100);
      chk("retire_in_time", int'(bus.PCWr), 1);
      @(posedge Clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input int mw, input exp_t e);
      bus.opcode = op;
      bus.funct  = fn;
      bus.Zero   = z;
      mem_wait   = mw;
      q.push_back(e);
      wait_done();
   endtask

   initial begin : stim
      int d0;
      int n;
      bus.opcode = 6'b000000;
      bus.funct  = 6'b100001;
      bus.Zero   = 1'b1;
      idle_ready = 1'b1;
      Reset      = 1'b1;
      repeat (3) begin
         @(negedge Clk);
         chk("reset_outputs", outs(), 0);
      end
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      bus.Zero = 1'b0;

      // addu with full state trace
      q.push_back(mk(4, 0, 1, 1, 0, 0, 0, 0, 4));
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         chk("addu_state", int'(bus.state), st_tr[i]);
         chk("addu_irwr", int'(bus.IRWr), (i == 0) ? 1 : 0);
      end
      @(posedge Clk);
      #1;
      chk("addu_back_to_if", int'(bus.state), 0);

      issue(6'b001001, 6'b000000, 1'b0, 0, mk(4, 0, 1, 1, 0, 0, 0, 0, 4));
      idle_ready = 1'b0;
      issue(6'b100011, 6'b000000, 1'b0, 3, mk(8, 0, 1, 1, 4, 0, 0, 0, 4));
      issue(6'b100011, 6'b000000, 1'b0, 0, mk(5, 0, 1, 1, 1, 0, 0, 0, 4));
      issue(6'b101011, 6'b000000, 1'b0, 0, mk(4, 0, 1, 0, 0, 1, 0, 0, 3));
      issue(6'b101011, 6'b000000, 1'b0, 1000,
            mk(19, 0, 1, 0, 0, 16, 0, 1, 3));
      issue(6'b100011, 6'b000000, 1'b0, 15,
            mk(20, 0, 1, 1, 16, 0, 0, 0, 4));
      issue(6'b100011, 6'b000000, 1'b0, 16,
            mk(19, 0, 1, 0, 16, 0, 0, 1, 3));
      issue(6'b000100, 6'b000000, 1'b1, 0, mk(3, 1, 1, 0, 0, 0, 0, 0, 2));
      issue(6'b000100, 6'b000000, 1'b0, 0, mk(3, 0, 1, 0, 0, 0, 0, 0, 2));

      d0 = n_done;
      issue(6'b000010, 6'b000000, 1'b0, 0, mk(2, 2, 1, 0, 0, 0, 0, 0, 1));
      issue(6'b000011, 6'b000000, 1'b0, 0, mk(2, 2, 1, 1, 0, 0, 0, 0, 1));
      issue(6'b000000, 6'b001000, 1'b0, 0, mk(3, 3, 1, 0, 0, 0, 0, 0, 2));
      issue(6'b111111, 6'b000000, 1'b0, 0, mk(2, 0, 1, 0, 0, 0, 1, 0, 1));
      chk("instr_done_count", n_done - d0, 4);

      // async reset in the middle of a stalled LW
      bus.opcode = 6'b100011;
      mem_wait   = 1000;
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (bus.state != 3'd3 && n < 20);
      chk("reached_mem", int'(bus.state), 3);
      repeat (2) @(negedge Clk);
      chk("memrd_before_reset", int'(bus.MemRd), 1);
      #2;
      Reset = 1'b1;
      #1;
      chk("memrd_async_drop", int'(bus.MemRd), 0);
      chk("outputs_async_reset", outs(), 0);
      repeat (2) begin
         @(negedge Clk);
         chk("outputs_in_reset", outs(), 0);
      end
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      chk("restart_state", int'(bus.state), 0);

      issue(6'b000000, 6'b100001, 1'b0, 0, mk(4, 0, 1, 1, 0, 0, 0, 0, 4));
      issue(6'b100011, 6'b000000, 1'b0, 15,
            mk(20, 0, 1, 1, 16, 0, 0, 0, 4));
      chk("queue_drained", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
Multicycle sequencer for the single-datapath MIPS core. It replaces the one-cycle-per-instruction flow with an IF/ID/EX/MEM/WB state machine. It drives the PC, IR, register-file and data-memory enables, and waits on a ready handshake from a variable-latency data memory. It sits beside the instruction decoder, which keeps generating ALUctr/ExtOp/ALUSrc/RegDst/MemtoReg; this block only decides when each enable fires.

Parameters:
TIMEOUT, 16, max cycles MEM waits for mem_ready before aborting the access (must be >= 1)
CNT_W, 5, width of the wait counter (must hold TIMEOUT)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
opcode  input  6  IR[31:26], stable from ID onward
funct  input  6  IR[5:0]
Zero  input  1  ALU zero flag, sampled in EX
mem_ready  input  1  data memory completes current access this cycle
IRWr  output  1  latch instruction into IR
PCWr  output  1  update PC this cycle
pc_src  output  2  00 PC+1, 01 branch target, 10 jump target, 11 BusA (jr)
RegWr  output  1  register-file write strobe
MemRd  output  1  data-memory read request
MemWr  output  1  data-memory write request
state  output  3  current state encoding, for debug
instr_done  output  1  equals PCWr; one pulse per retired instruction
illegal  output  1  one-cycle pulse: undecodable instruction skipped
bus_err  output  1  one-cycle pulse: MEM access timed out

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4. Codes 5-7 are unreachable and return to IF on the next edge.
- State register and wait counter reset asynchronously to IF / 0.
- Outputs are combinational from state, opcode, funct, Zero, mem_ready and the counter. All outputs are forced to 0 while Reset is high.
- Decode classes:
  - R: opcode 000000 with funct != 001000
  - JR: opcode 000000 with funct 001000
  - I: opcode[5:3] == 001
  - LW: 100011
  - SW: 101011
  - BEQ: 000100
  - J: 000010
  - JAL: 000011
  - anything else is illegal.
- IF: IRWr=1, go to ID.
- ID:
  - J: PCWr=1, pc_src=10, go to IF.
  - JAL: PCWr=1, pc_src=10, RegWr=1 (link), go to IF.
  - Illegal: illegal=1, PCWr=1, pc_src=00, go to IF.
  - All others: go to EX.
- EX:
  - R or I: go to WB.
  - LW or SW: clear counter, go to MEM.
  - BEQ: PCWr=1, pc_src = Zero ? 01 : 00, go to IF.
  - JR: PCWr=1, pc_src=11, go to IF.
- MEM:
  - MemRd=1 (LW) or MemWr=1 (SW), held every cycle until exit.
  - mem_ready=1:
    - LW: go to WB.
    - SW: PCWr=1, pc_src=00, go to IF.
  - mem_ready=0 and counter == TIMEOUT-1: bus_err=1, PCWr=1, pc_src=00, go to IF. No register write occurs.
  - Otherwise the counter increments. The counter saturates and never wraps.
  - mem_ready high in the same cycle the counter hits TIMEOUT-1: completion wins, no bus_err.
- WB: RegWr=1, PCWr=1, pc_src=00, go to IF.
- Latencies with mem_ready already high on entry to MEM:
  - R/I: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ/JR: 3 cycles
  - J/JAL: 2 cycles
  - illegal: 2 cycles
  - Each cycle of mem_ready low adds 1.
- mem_ready outside MEM is ignored.
- Reset mid-instruction (any state, including MEM with a request pending):
  - All strobes drop immediately.
  - The state machine restarts at IF on the first edge after Reset deasserts.
  - No partial write completes.
- Exactly one PCWr pulse per instruction, always in that instruction's final cycle.
- RegWr and MemWr are never both high.

Test Plan:
- Reset held 3 cycles then released, opcode=000000 funct=100001 (addu): state 0,1,2,4,0. IRWr in cycle 1, RegWr+PCWr (pc_src=00) in cycle 4 only; all outputs 0 during reset.
- LW (100011) with mem_ready low for 3 MEM cycles then high: MemRd high for exactly 4 cycles, then WB with RegWr=1. Total 8 cycles, bus_err stays 0.
- SW (101011), TIMEOUT=16, mem_ready never asserted: MemWr high 16 cycles, then bus_err=1 and PCWr=1 in the 16th MEM cycle. No RegWr; next state IF.
- BEQ (000100): with Zero=1, EX gives PCWr=1 and pc_src=01. With Zero=0, pc_src=00. 3 cycles each.
- Back-to-back J (000010), JAL (000011), JR (funct 001000), then opcode 111111: pc_src 10/10/11/00 respectively. JAL gives RegWr=1 in ID; the 111111 instruction gives an illegal pulse in ID. instr_done count = 4.
- Assert Reset asynchronously mid-MEM of an LW while mem_ready=0: MemRd drops in the same cycle, no RegWr ever. After release the sequence restarts from IF with counter=0.
